// File: rtl/instr_prefetch_pkg.sv
// Shared types for the instruction prefetch stage: address/instruction
// widths, the fetched {pc, raw} pair and the memory request record.
package instr_prefetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    addr_t  pc;
    instr_t raw;
  } fetched_t;

  typedef struct packed {
    addr_t       a;
    logic        we;
    logic [3:0]  be;
    logic [31:0] d;
  } mem_req_t;

  localparam int FETCHED_W = $bits(fetched_t);
  localparam int MEM_REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Small synchronous FIFO with push, pop, synchronous clear, head, empty and
// occupancy count. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write.
  // NOTE: the data array is not reset; empty/count gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Pipelined instruction fetch stage: issues PCs to memory on credit, pairs
// in-order responses with their PCs and hands {pc, raw} downstream. A flush
// empties both FIFOs and marks in-flight responses for discard.
// Optional build macro: INSTR_PREFETCH_BYPASS_EN -- a response arriving into an
// empty data FIFO drives fetched in the same cycle.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_valid,
  output logic                 pc_ready,
  input  logic [ADDR_W-1:0]    pc_data,
  output logic                 fetched_valid,
  input  logic                 fetched_ready,
  output logic [FETCHED_W-1:0] fetched_data,
  input  logic                 flush,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [MEM_REQ_W-1:0] mem_req_data,
  input  logic                 mem_resp_valid,
  output logic                 mem_resp_ready,
  input  logic [INSTR_W-1:0]   mem_resp_data
);

  logic [CNT_W-1:0] outstanding, discard, out_nxt, disc_nxt;
  logic [CNT_W-1:0] occ, pc_count, data_count;
  addr_t            pc_head;
  instr_t           data_head, raw_out;
  logic             pc_empty, data_empty;
  logic             resp_fire, drop_resp, drain, issue, has_credit, bypass;
  logic             data_push, data_pop;
  logic [1:0]       frees;

  assign mem_resp_ready = !rst;
  assign resp_fire      = mem_resp_valid && mem_resp_ready;
  assign drop_resp      = resp_fire && (flush || discard != '0);
  assign occ            = outstanding + data_count;

`ifdef INSTR_PREFETCH_BYPASS_EN
  assign bypass  = data_empty && (discard == '0) && resp_fire && !flush;
  assign raw_out = data_empty ? mem_resp_data : data_head;
`else
  assign bypass  = 1'b0;
  assign raw_out = data_head;
`endif

  assign fetched_valid = (!data_empty || bypass) && !flush && !rst;
  assign drain         = fetched_valid && fetched_ready;
  assign fetched_data  = fetched_t'{pc: pc_head, raw: raw_out};

  // A drain or a discarded response frees a slot in the same cycle.
  assign frees      = {1'b0, drain} + {1'b0, drop_resp};
  assign has_credit = {1'b0, occ} < ((CNT_W+1)'(DEPTH) + (CNT_W+1)'(frees));

  assign mem_req_valid = pc_valid && has_credit && !flush && !rst;
  assign pc_ready      = mem_req_ready && has_credit && !flush && !rst;
  assign issue         = mem_req_valid && mem_req_ready;
  assign mem_req_data  = mem_req_t'{a: pc_data, we: 1'b0, be: '0, d: '0};

  assign data_push = resp_fire && !drop_resp && !(bypass && drain);
  assign data_pop  = drain && !data_empty;

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (issue),
    .pop  (drain),
    .din  (pc_data),
    .head (pc_head),
    .empty(pc_empty),
    .count(pc_count)
  );

  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (data_push),
    .pop  (data_pop),
    .din  (mem_resp_data),
    .head (data_head),
    .empty(data_empty),
    .count(data_count)
  );

  // Next outstanding/discard counts; a flush re-arms discard from what is still in flight.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    out_nxt  = outstanding + CNT_W'(issue) - CNT_W'(resp_fire);
    disc_nxt = discard;
    if (flush)
      disc_nxt = outstanding - CNT_W'(resp_fire);
    else if (resp_fire && discard != '0)
      disc_nxt = discard - CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      discard     <= disc_nxt;
    end
  end

`ifndef SYNTHESIS
  a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
    resp_fire |-> outstanding != '0);
  a_fetched_stable: assert property (@(posedge clk) disable iff (rst)
    fetched_valid && !fetched_ready |=> $stable(fetched_data));
  a_pc_tracks_work: assert property (@(posedge clk) disable iff (rst)
    pc_count == outstanding - discard + data_count);
  a_fetched_has_pc: assert property (@(posedge clk) disable iff (rst)
    fetched_valid |-> !pc_empty);
`endif

endmodule
